// File: rtl/register_read_control.sv
// Operand-fetch sequencer: reads rs1 then rs2 through the register file's single synchronous
// read port, substitutes zero for x0/unused operands and presents both latched values.

`ifndef STAGE_WIDTH
`define STAGE_WIDTH 3
`endif
`ifndef STAGE_REGISTER_READ
`define STAGE_REGISTER_READ 3'd2
`endif

module register_read_control #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [`STAGE_WIDTH-1:0] stage,
  input  logic [6:0]              opcode,
  input  logic [4:0]              rs1,
  input  logic [4:0]              rs2,
  output logic                    rf_read_enable,
  output logic [4:0]              rf_read_addr,
  input  logic [31:0]             rf_read_data,
  output logic [31:0]             rs1_value,
  output logic [31:0]             rs2_value,
  output logic                    operands_valid,
  output logic                    busy
);

  localparam logic [6:0] OpAluRegs = 7'b0110011;
  localparam logic [6:0] OpBranch  = 7'b1100011;
  localparam logic [6:0] OpStore   = 7'b0100011;
  localparam logic [6:0] OpAluImm  = 7'b0010011;
  localparam logic [6:0] OpLoad    = 7'b0000011;
  localparam logic [6:0] OpJalr    = 7'b1100111;

  localparam int unsigned   CntW    = (READ_LATENCY > 1) ? 2 : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(READ_LATENCY);

  typedef enum logic [1:0] {StIdle, StRd1, StRd2, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      addr_q, addr_d;
  logic [31:0]     rs1_value_q, rs1_value_d;
  logic [31:0]     rs2_value_q, rs2_value_d;
  logic            valid_q, valid_d;

  logic need1, need2, fetch1, fetch2, in_rr, last;

  always_comb begin
    need1 = 1'b0;
    need2 = 1'b0;
    case (opcode)
      OpAluRegs, OpBranch, OpStore: begin
        need1 = 1'b1;
        need2 = 1'b1;
      end
      OpAluImm, OpLoad, OpJalr: need1 = 1'b1;
      default: ;
    endcase
  end

  assign fetch1 = need1 && (rs1 != 5'd0);
  assign fetch2 = need2 && (rs2 != 5'd0);
  assign in_rr  = (stage == `STAGE_REGISTER_READ);
  assign last   = (cnt_q == CntLast);

  // IDLE is only re-entered once stage has left register-read (DONE exit, abort)
  // or from reset, so seeing register-read in IDLE marks a fresh stage entry.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rs1_value_d = rs1_value_q;
    rs2_value_d = rs2_value_q;
    valid_d     = valid_q;
    unique case (state_q)
      StIdle: begin
        if (in_rr) begin
          rs1_value_d = '0;
          rs2_value_d = '0;
          valid_d     = 1'b0;
          cnt_d       = '0;
          if (fetch1) begin
            state_d = StRd1;
            addr_d  = rs1;
          end else if (fetch2) begin
            state_d = StRd2;
            addr_d  = rs2;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRd1: begin
        if (!in_rr) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (last) begin
          rs1_value_d = rf_read_data;
          cnt_d       = '0;
          if (fetch2) begin
            state_d = StRd2;
            addr_d  = rs2;
          end else begin
            state_d = StDone;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRd2: begin
        if (!in_rr) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (last) begin
          rs2_value_d = rf_read_data;
          cnt_d       = '0;
          state_d     = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        valid_d = 1'b1;
        if (!in_rr) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      rs1_value_q <= '0;
      rs2_value_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rs1_value_q <= rs1_value_d;
      rs2_value_q <= rs2_value_d;
      valid_q     <= valid_d;
    end
  end

  // The strobe is the first cycle of each read state; the counter is part of the state.
  assign rf_read_enable = ((state_q == StRd1) || (state_q == StRd2)) && (cnt_q == '0);
  assign busy           = (state_q == StRd1) || (state_q == StRd2);
  assign rf_read_addr   = addr_q;
  assign rs1_value      = rs1_value_q;
  assign rs2_value      = rs2_value_q;
  assign operands_valid = valid_q;

endmodule

// File: tb/tb_register_read_control.sv
// Bench for register_read_control: two instances (read latency 1 and 3) driven by directed
// and random instructions, checked against an operand-need / timing model.

`ifndef STAGE_WIDTH
`define STAGE_WIDTH 3
`endif
`ifndef STAGE_REGISTER_READ
`define STAGE_REGISTER_READ 3'd2
`endif

module tb_register_read_control;

  localparam logic [`STAGE_WIDTH-1:0] StageRr    = `STAGE_REGISTER_READ;
  localparam logic [`STAGE_WIDTH-1:0] StageFetch = 3'd0;
  localparam logic [`STAGE_WIDTH-1:0] StageEx    = 3'd3;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  logic clk = 1'b0;
  logic reset_n;
  logic [`STAGE_WIDTH-1:0] stage [2];
  logic [6:0]  opcode [2];
  logic [4:0]  rs1 [2];
  logic [4:0]  rs2 [2];
  logic        en [2];
  logic [4:0]  addr [2];
  logic [31:0] rdata [2];
  logic [31:0] v1 [2];
  logic [31:0] v2 [2];
  logic        valid [2];
  logic        busy [2];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] mem [2][32];
  logic [31:0] pipe [2][3];
  int          st_cyc [2][$];
  logic [4:0]  st_addr [2][$];

  int S, base, obs_lat, obs_busy, obs_n, obs_extra;
  logic [31:0] obs_v1, obs_v2;
  logic        obs_valid_after;

  always #5 clk = ~clk;

  register_read_control #(.READ_LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset_n(reset_n), .stage(stage[0]), .opcode(opcode[0]), .rs1(rs1[0]),
    .rs2(rs2[0]), .rf_read_enable(en[0]), .rf_read_addr(addr[0]), .rf_read_data(rdata[0]),
    .rs1_value(v1[0]), .rs2_value(v2[0]), .operands_valid(valid[0]), .busy(busy[0])
  );

  register_read_control #(.READ_LATENCY(3)) u_dut_l3 (
    .clk(clk), .reset_n(reset_n), .stage(stage[1]), .opcode(opcode[1]), .rs1(rs1[1]),
    .rs2(rs2[1]), .rf_read_enable(en[1]), .rf_read_addr(addr[1]), .rf_read_data(rdata[1]),
    .rs1_value(v1[1]), .rs2_value(v2[1]), .operands_valid(valid[1]), .busy(busy[1])
  );

  // Register file: data appears N cycles after a strobe, garbage otherwise.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      pipe[i][0] <= (en[i] === 1'b1) ? mem[i][addr[i]] : $urandom;
      pipe[i][1] <= pipe[i][0];
      pipe[i][2] <= pipe[i][1];
    end
  end
  assign rdata[0] = pipe[0][0];
  assign rdata[1] = pipe[1][2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (en[i] === 1'b1) begin
        st_cyc[i].push_back(cyc);
        st_addr[i].push_back(addr[i]);
      end
    end
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Number of source operands the instruction class reads.
  function automatic int need_of(input logic [6:0] op);
    if (op == OpR || op == OpBranch || op == OpStore) return 2;
    if (op == OpImm || op == OpLoad || op == OpJalr) return 1;
    return 0;
  endfunction

  // Runs one instruction through register-read, records observations, then leaves the stage.
  task automatic run_seq(input int i, input logic [6:0] op, input logic [4:0] a,
                         input logic [4:0] b);
    @(negedge clk);
    opcode[i] = op; rs1[i] = a; rs2[i] = b; stage[i] = StageRr;
    base = st_cyc[i].size();
    @(posedge clk); #1;
    S = cyc;
    obs_lat = -1; obs_busy = 0;
    for (int k = 0; k < 40 && obs_lat < 0; k++) begin
      @(negedge clk);
      if (valid[i] === 1'b1) obs_lat = cyc - S;
      else if (busy[i] === 1'b1) obs_busy++;
    end
    obs_v1 = v1[i]; obs_v2 = v2[i];
    obs_n = st_cyc[i].size() - base;
    @(negedge clk); @(negedge clk);
    stage[i] = StageEx;
    repeat (3) @(negedge clk);
    obs_valid_after = valid[i];
    obs_extra = st_cyc[i].size() - base - obs_n;
  endtask

  task automatic test_reset();
    checks++; if ({en[0], addr[0], v1[0], v2[0], valid[0], busy[0]} !== '0) begin
      errors++; $display("FAIL reset_init got en=%b addr=%0d v1=%h v2=%h valid=%b busy=%b want 0",
                         en[0], addr[0], v1[0], v2[0], valid[0], busy[0]); end
    checks++; if ({en[1], addr[1], v1[1], v2[1], valid[1], busy[1]} !== '0) begin
      errors++; $display("FAIL reset_init_l3 got en=%b valid=%b busy=%b want 0",
                         en[1], valid[1], busy[1]); end
    @(negedge clk); reset_n = 1'b1;
    base = st_cyc[0].size();
    repeat (4) @(negedge clk);
    checks++; if (st_cyc[0].size() - base !== 0) begin
      errors++; $display("FAIL reset_no_strobe got %0d strobes want 0", st_cyc[0].size() - base);
    end
    // Start an R-type, then hit reset during the rs2 read.
    mem[0][5] = 32'h11111111; mem[0][6] = 32'h22222222;
    opcode[0] = OpR; rs1[0] = 5'd5; rs2[0] = 5'd6; stage[0] = StageRr;
    @(posedge clk); #1; S = cyc;
    while (cyc < S + 3) @(negedge clk);
    #2; reset_n = 1'b0; stage[0] = StageFetch;
    #1;
    checks++; if ({en[0], addr[0], v1[0], v2[0], valid[0], busy[0]} !== '0) begin
      errors++; $display("FAIL reset_mid got en=%b addr=%0d v1=%h v2=%h valid=%b busy=%b want 0",
                         en[0], addr[0], v1[0], v2[0], valid[0], busy[0]); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    base = st_cyc[0].size();
    repeat (5) @(negedge clk);
    checks++; if (st_cyc[0].size() - base !== 0 || busy[0] !== 1'b0) begin
      errors++; $display("FAIL reset_release got strobes=%0d busy=%b want 0 0",
                         st_cyc[0].size() - base, busy[0]); end
  endtask

  task automatic test_rtype();
    mem[0][5] = 32'h11111111; mem[0][6] = 32'h22222222;
    run_seq(0, OpR, 5'd5, 5'd6);
    checks++; if (obs_lat !== 5) begin
      errors++; $display("FAIL rtype_lat got %0d want 5", obs_lat); end
    checks++; if (obs_n !== 2) begin
      errors++; $display("FAIL rtype_strobes got %0d want 2", obs_n); end
    if (obs_n >= 2) begin
      checks++; if (st_addr[0][base] !== 5'd5 || st_addr[0][base+1] !== 5'd6) begin
        errors++; $display("FAIL rtype_addr got %0d,%0d want 5,6",
                           st_addr[0][base], st_addr[0][base+1]); end
      checks++; if (st_cyc[0][base] - S !== 0 || st_cyc[0][base+1] - st_cyc[0][base] !== 2) begin
        errors++; $display("FAIL rtype_spacing got off=%0d gap=%0d want 0 2",
                           st_cyc[0][base] - S, st_cyc[0][base+1] - st_cyc[0][base]); end
    end
    checks++; if (obs_v1 !== 32'h11111111 || obs_v2 !== 32'h22222222) begin
      errors++; $display("FAIL rtype_values got %h %h want 11111111 22222222", obs_v1, obs_v2); end
    checks++; if (obs_busy !== 4) begin
      errors++; $display("FAIL rtype_busy got %0d cycles want 4", obs_busy); end
    checks++; if (obs_valid_after !== 1'b1 || obs_extra !== 0) begin
      errors++; $display("FAIL rtype_after got valid=%b extra=%0d want 1 0",
                         obs_valid_after, obs_extra); end
  endtask

  task automatic test_zero_skip();
    run_seq(0, OpLoad, 5'd0, 5'd7);
    checks++; if (obs_lat !== 1 || obs_n !== 0) begin
      errors++; $display("FAIL load_x0 got lat=%0d strobes=%0d want 1 0", obs_lat, obs_n); end
    checks++; if (obs_v1 !== 32'h0 || obs_v2 !== 32'h0) begin
      errors++; $display("FAIL load_x0_values got %h %h want 0 0", obs_v1, obs_v2); end
  endtask

  task automatic test_op_imm();
    mem[0][3] = 32'hDEADBEEF; mem[0][9] = 32'h99999999;
    run_seq(0, OpImm, 5'd3, 5'd9);
    checks++; if (obs_lat !== 3 || obs_n !== 1) begin
      errors++; $display("FAIL opimm got lat=%0d strobes=%0d want 3 1", obs_lat, obs_n); end
    if (obs_n >= 1) begin
      checks++; if (st_addr[0][base] !== 5'd3) begin
        errors++; $display("FAIL opimm_addr got %0d want 3", st_addr[0][base]); end
    end
    checks++; if (obs_v1 !== 32'hDEADBEEF || obs_v2 !== 32'h0) begin
      errors++; $display("FAIL opimm_values got %h %h want deadbeef 0", obs_v1, obs_v2); end
  endtask

  task automatic test_abort();
    mem[0][1] = 32'hA1A1A1A1; mem[0][2] = 32'hB2B2B2B2;
    @(negedge clk);
    opcode[0] = OpStore; rs1[0] = 5'd1; rs2[0] = 5'd2; stage[0] = StageRr;
    base = st_cyc[0].size();
    @(posedge clk); #1; S = cyc;
    while (cyc < S + 2) @(negedge clk);
    checks++; if (busy[0] !== 1'b1 || en[0] !== 1'b1 || addr[0] !== 5'd2) begin
      errors++; $display("FAIL abort_in_rd2 got busy=%b en=%b addr=%0d want 1 1 2",
                         busy[0], en[0], addr[0]); end
    stage[0] = StageEx;
    repeat (6) @(negedge clk);
    checks++; if (valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++; $display("FAIL abort_state got valid=%b busy=%b want 0 0", valid[0], busy[0]); end
    checks++; if (st_cyc[0].size() - base !== 2) begin
      errors++; $display("FAIL abort_strobes got %0d want 2", st_cyc[0].size() - base); end
    checks++; if (v1[0] !== 32'hA1A1A1A1 || v2[0] !== 32'h0) begin
      errors++; $display("FAIL abort_partial got %h %h want a1a1a1a1 0", v1[0], v2[0]); end
    run_seq(0, OpStore, 5'd1, 5'd2);
    checks++; if (obs_lat !== 5 || obs_n !== 2) begin
      errors++; $display("FAIL abort_restart got lat=%0d strobes=%0d want 5 2", obs_lat, obs_n); end
    if (obs_n >= 1) begin
      checks++; if (st_addr[0][base] !== 5'd1 || st_cyc[0][base] - S !== 0) begin
        errors++; $display("FAIL abort_restart_rd1 got addr=%0d off=%0d want 1 0",
                           st_addr[0][base], st_cyc[0][base] - S); end
    end
    checks++; if (obs_v1 !== 32'hA1A1A1A1 || obs_v2 !== 32'hB2B2B2B2) begin
      errors++; $display("FAIL abort_restart_values got %h %h want a1a1a1a1 b2b2b2b2",
                         obs_v1, obs_v2); end
  endtask

  task automatic test_branch_lat3();
    mem[1][4] = 32'h80000000;
    run_seq(1, OpBranch, 5'd4, 5'd4);
    checks++; if (obs_lat !== 9 || obs_n !== 2) begin
      errors++; $display("FAIL lat3_branch got lat=%0d strobes=%0d want 9 2", obs_lat, obs_n); end
    if (obs_n >= 2) begin
      checks++; if (st_addr[1][base] !== 5'd4 || st_addr[1][base+1] !== 5'd4 ||
                    st_cyc[1][base+1] - st_cyc[1][base] !== 4) begin
        errors++; $display("FAIL lat3_strobes got %0d,%0d gap=%0d want 4,4 gap 4",
                           st_addr[1][base], st_addr[1][base+1],
                           st_cyc[1][base+1] - st_cyc[1][base]); end
    end
    checks++; if (obs_v1 !== 32'h80000000 || obs_v2 !== 32'h80000000) begin
      errors++; $display("FAIL lat3_values got %h %h want 80000000 80000000", obs_v1, obs_v2); end
  endtask

  task automatic test_random();
    logic [6:0] ops [10];
    ops = '{OpR, OpBranch, OpStore, OpImm, OpLoad, OpJalr, OpLui, OpAuipc, OpJal, 7'h7F};
    for (int t = 0; t < 24; t++) begin
      int i, need, n, L, exp_lat, k;
      logic [6:0] op;
      logic [4:0] a, b;
      logic f1, f2;
      logic [4:0] exp_addr [2];
      int exp_off [2];
      i = t % 2;
      L = lat_of(i);
      op = ops[$urandom_range(0, 9)];
      a = 5'($urandom_range(0, 7));
      b = 5'($urandom_range(0, 7));
      for (int r = 1; r < 32; r++) mem[i][r] = $urandom;
      need = need_of(op);
      f1 = (need >= 1) && (a != 0);
      f2 = (need == 2) && (b != 0);
      n = 0;
      if (f1) begin exp_addr[n] = a; exp_off[n] = 0; n++; end
      if (f2) begin exp_addr[n] = b; exp_off[n] = f1 ? (1 + L) : 0; n++; end
      exp_lat = n * (1 + L) + 1;
      run_seq(i, op, a, b);
      checks++; if (obs_lat !== exp_lat || obs_n !== n) begin
        errors++; $display("FAIL rand%0d_timing op=%b got lat=%0d strobes=%0d want %0d %0d",
                           t, op, obs_lat, obs_n, exp_lat, n); end
      k = (obs_n < n) ? obs_n : n;
      for (int j = 0; j < k; j++) begin
        checks++;
        if (st_addr[i][base+j] !== exp_addr[j] || st_cyc[i][base+j] - S !== exp_off[j]) begin
          errors++; $display("FAIL rand%0d_strobe%0d got addr=%0d off=%0d want %0d %0d", t, j,
                             st_addr[i][base+j], st_cyc[i][base+j] - S, exp_addr[j], exp_off[j]);
        end
      end
      checks++; if (obs_v1 !== (f1 ? mem[i][a] : 32'h0) || obs_v2 !== (f2 ? mem[i][b] : 32'h0))
      begin
        errors++; $display("FAIL rand%0d_values got %h %h want %h %h", t, obs_v1, obs_v2,
                           f1 ? mem[i][a] : 32'h0, f2 ? mem[i][b] : 32'h0); end
      checks++; if (obs_busy !== n * (1 + L) || obs_valid_after !== 1'b1 || obs_extra !== 0)
      begin
        errors++; $display("FAIL rand%0d_busy got busy=%0d valid=%b extra=%0d want %0d 1 0", t,
                           obs_busy, obs_valid_after, obs_extra, n * (1 + L)); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      stage[i] = StageFetch; opcode[i] = '0; rs1[i] = '0; rs2[i] = '0;
      for (int r = 0; r < 32; r++) mem[i][r] = (r == 0) ? 32'h0 : $urandom;
    end
    #1;
    test_reset();
    test_rtype();
    test_zero_skip();
    test_op_imm();
    test_abort();
    test_branch_lat3();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
